// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : watch_pkg
// Brief    : Shared watch constants: button indices, default debounce and
//            auto-repeat timing derived from the system clock rate, and the
//            auto-repeat state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package watch_pkg;

  localparam int CLK_HZ  = 1_000_000;
  localparam int NUM_BTN = 6;

  // Button bit positions on every N_BTN-wide bus
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ENTER = 4;
  localparam int BTN_ESC   = 5;

  // 20 ms debounce, 500 ms to first repeat, 100 ms between repeats
  localparam int DEBOUNCE_CYC_DEF  = CLK_HZ / 50;
  localparam int REPEAT_DELAY_DEF  = CLK_HZ / 2;
  localparam int REPEAT_PERIOD_DEF = CLK_HZ / 10;

  // Only the value-setting buttons auto-repeat by default
  localparam logic [NUM_BTN-1:0] REPEAT_MASK_DEF =
      (NUM_BTN'(1) << BTN_UP) | (NUM_BTN'(1) << BTN_DOWN);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Counter width able to hold max_val; counters clear at their terminal
  // value so they never need to saturate.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : One raw active-low button: 2-flop synchroniser, stable-count
//            debouncer, registered press/release pulses and an optional
//            auto-repeat timer that re-fires press pulses while held.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             sync_pressed;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             rise;
  logic             fall;
  logic             rpt_pulse;

  // Two-flop synchroniser; resets to "released" so a held button is seen
  // as a fresh press after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign sync_pressed = ~sync2_q;

  // Count consecutive cycles the synced input disagrees with the accepted
  // level; accept the new level when the count reaches its terminal value.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (sync_pressed != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync_pressed;
        rise    = sync_pressed;
        fall    = ~sync_pressed;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Repeat pulses never coincide with a release: the release forces IDLE.
  assign press_d   = rise | rpt_pulse;
  assign release_d = fall;

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RCNT_W  = cnt_width(RPT_MAX);
      localparam logic [RCNT_W-1:0] DLY_LAST = RCNT_W'(REPEAT_DELAY - 1);
      localparam logic [RCNT_W-1:0] PER_LAST = RCNT_W'(REPEAT_PERIOD - 1);

      rpt_state_e        state_q, state_d;
      logic [RCNT_W-1:0] rcnt_q, rcnt_d;

      // Repeat state and timer registers
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= RPT_IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end

      // Initial hold delay, then fixed-period ticks until release
      always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        rpt_pulse = 1'b0;
        if (fall) begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end else begin
          case (state_q)
            RPT_IDLE: begin
              if (rise) begin
                state_d = RPT_DELAY;
                rcnt_d  = '0;
              end
            end
            RPT_DELAY: begin
              if (rcnt_q == DLY_LAST) begin
                state_d   = RPT_REPEAT;
                rcnt_d    = '0;
                rpt_pulse = 1'b1;
              end else begin
                rcnt_d = rcnt_q + RCNT_W'(1);
              end
            end
            RPT_REPEAT: begin
              if (rcnt_q == PER_LAST) begin
                rcnt_d    = '0;
                rpt_pulse = 1'b1;
              end else begin
                rcnt_d = rcnt_q + RCNT_W'(1);
              end
            end
            default: begin
              state_d = RPT_IDLE;
              rcnt_d  = '0;
            end
          endcase
        end
      end
    end else begin : g_no_repeat
      assign rpt_pulse = 1'b0;
    end
  endgenerate

  // Accepted level, debounce counter and one-cycle output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Watch button front end. Synchronises, debounces and edge-detects
//            the raw active-low buttons into clean levels and one-cycle
//            press/release pulses; masked buttons auto-repeat while held.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
  import watch_pkg::*;
#(
  parameter int               N_BTN         = NUM_BTN,
  parameter int               DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int               REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int               REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(REPEAT_MASK_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o
);

  // Buttons are fully independent; one conditioner per bit, no priority.
  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .REPEAT_EN     (REPEAT_MASK[i])
      ) u_btn (
        .clk       (clk),
        .rst       (rst),
        .btn_n_i   (btn_n_i[i]),
        .level_o   (level_o[i]),
        .press_o   (press_o[i]),
        .release_o (release_o[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire
